// File: rtl/reg_file_dump.sv
// Debug read-out sequencer: takes over the reg_file read ports, walks x0..x(NREGS-1)
// two registers per read, and streams {index, value} over a valid/ready port.
module reg_file_dump #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [4:0]    rr1,
  output logic [4:0]    rr2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout_data,
  output logic [4:0]    dout_idx,
  output logic          busy,
  output logic          core_stall,
  output logic          done,
  output logic [2:0]    dbg_state
);

  // Stream handshake: a word transfers on a cycle where dout_valid and dout_ready are
  // both high; while valid is high and ready low, dout_data/dout_idx hold unchanged.

  localparam int              KW     = 4;
  localparam logic [KW-1:0]   K_LAST = KW'(NREGS / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_SEND0 = 3'd2,
    S_SEND1 = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] k_inc;
  logic [4:0]    rr1_q, rr1_d;
  logic [4:0]    rr2_q, rr2_d;
  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      rr1_q   <= '0;
      rr2_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rr1_q   <= rr1_d;
      rr2_q   <= rr2_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  assign k_inc = k_q + KW'(1);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rr1_d   = rr1_q;
    rr2_d   = rr2_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    if (abort) begin
      state_d = S_IDLE;
      k_d     = '0;
      rr1_d   = '0;
      rr2_d   = '0;
      buf0_d  = '0;
      buf1_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_READ;
            k_d     = '0;
            rr1_d   = 5'd0;
            rr2_d   = 5'd1;
          end
        end
        S_READ: begin
          buf0_d  = rd1;
          buf1_d  = rd2;
          state_d = S_SEND0;
        end
        S_SEND0: begin
          if (dout_ready) state_d = S_SEND1;
        end
        S_SEND1: begin
          if (dout_ready) begin
            if (k_q == K_LAST) begin
              state_d = S_DONE;
              rr1_d   = '0;
              rr2_d   = '0;
            end else begin
              // Addresses for the next pair are loaded here so they are stable all READ.
              state_d = S_READ;
              k_d     = k_inc;
              rr1_d   = {k_inc, 1'b0};
              rr2_d   = {k_inc, 1'b1};
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          k_d     = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign rr1        = rr1_q;
  assign rr2        = rr2_q;
  assign dout_valid = (state_q == S_SEND0) || (state_q == S_SEND1);
  assign dout_data  = (state_q == S_SEND0) ? buf0_q :
                      (state_q == S_SEND1) ? buf1_q : '0;
  assign dout_idx   = dout_valid ? {k_q, (state_q == S_SEND1)} : 5'd0;
  assign busy       = (state_q != S_IDLE);
  assign core_stall = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign dbg_state  = state_q;

endmodule
